// File: rtl/float_norm_pipe.sv
// Two-stage leading-zero / normalise / population-count unit with valid/ready
// handshake and a sideband tag carried alongside each operand.
module float_norm_pipe #(
    parameter  int unsigned WIDTH = 48,
    parameter  int unsigned GROUP = 8,
    parameter  int unsigned TAG_W = 7,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [CNT_W-1:0] o_cnt,
    output logic [WIDTH-1:0] o_norm,
    output logic             o_zero,
    output logic [TAG_W-1:0] o_tag
);

    localparam int unsigned NG   = WIDTH / GROUP;
    localparam int unsigned LZ_W = $clog2(GROUP);
    localparam int unsigned PC_W = $clog2(GROUP + 1);

    logic adv;

    logic [NG-1:0]            grp_nz_c;
    logic [NG-1:0][LZ_W-1:0]  grp_lz_c;
    logic [NG-1:0][PC_W-1:0]  grp_pc_c;

    logic                     s1_valid_q, s1_valid_d;
    logic                     s1_mode_q,  s1_mode_d;
    logic [WIDTH-1:0]         s1_data_q,  s1_data_d;
    logic [TAG_W-1:0]         s1_tag_q,   s1_tag_d;
    logic [NG-1:0]            s1_nz_q,    s1_nz_d;
    logic [NG-1:0][LZ_W-1:0]  s1_lz_q,    s1_lz_d;
    logic [NG-1:0][PC_W-1:0]  s1_pc_q,    s1_pc_d;

    logic [CNT_W-1:0]         lz_cnt_c;
    logic [CNT_W-1:0]         pop_cnt_c;

    logic                     o_valid_q, o_valid_d;
    logic [CNT_W-1:0]         cnt_q,     cnt_d;
    logic [WIDTH-1:0]         norm_q,    norm_d;
    logic                     zero_q,    zero_d;
    logic [TAG_W-1:0]         tag_q,     tag_d;

    // Both stages move together; no skid buffer, so a stalled output blocks input.
    assign adv     = ~o_valid_q | i_ready;
    assign o_ready = adv;

    assign o_valid = o_valid_q;
    assign o_cnt   = cnt_q;
    assign o_norm  = norm_q;
    assign o_zero  = zero_q;
    assign o_tag   = tag_q;

    // Per-group nonzero flag, leading-zero count and popcount of the incoming operand.
    always_comb begin
        grp_nz_c = '0;
        grp_lz_c = '0;
        grp_pc_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            grp_nz_c[g] = |i_data[g*GROUP +: GROUP];
            for (int unsigned b = 0; b < GROUP; b++) begin
                // Ascending scan: the last hit is the highest set bit.
                if (i_data[g*GROUP + b]) begin
                    grp_lz_c[g] = LZ_W'(GROUP - 1 - b);
                end
                grp_pc_c[g] = grp_pc_c[g] + PC_W'(i_data[g*GROUP + b]);
            end
        end
    end

    // Stage-1 next state.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s1_tag_d   = s1_tag_q;
        s1_nz_d    = s1_nz_q;
        s1_lz_d    = s1_lz_q;
        s1_pc_d    = s1_pc_q;
        if (adv) begin
            s1_valid_d = i_valid;
            s1_mode_d  = i_mode;
            s1_data_d  = i_data;
            s1_tag_d   = i_tag;
            s1_nz_d    = grp_nz_c;
            s1_lz_d    = grp_lz_c;
            s1_pc_d    = grp_pc_c;
        end
    end

    // Combine group results: highest nonzero group wins for LZ; popcounts are summed.
    always_comb begin
        lz_cnt_c  = CNT_W'(WIDTH);
        pop_cnt_c = '0;
        for (int unsigned g = 0; g < NG; g++) begin
            if (s1_nz_q[g]) begin
                lz_cnt_c = CNT_W'((NG - 1 - g) * GROUP) + CNT_W'(s1_lz_q[g]);
            end
            pop_cnt_c = pop_cnt_c + CNT_W'(s1_pc_q[g]);
        end
    end

    // Stage-2 (output) next state; a zero operand shifts out completely in mode 0.
    always_comb begin
        o_valid_d = o_valid_q;
        cnt_d     = cnt_q;
        norm_d    = norm_q;
        zero_d    = zero_q;
        tag_d     = tag_q;
        if (adv) begin
            o_valid_d = s1_valid_q;
            cnt_d     = s1_mode_q ? pop_cnt_c : lz_cnt_c;
            norm_d    = s1_mode_q ? s1_data_q : (s1_data_q << lz_cnt_c);
            zero_d    = ~|s1_nz_q;
            tag_d     = s1_tag_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_tag_q   <= '0;
            s1_nz_q    <= '0;
            s1_lz_q    <= '0;
            s1_pc_q    <= '0;
            o_valid_q  <= 1'b0;
            cnt_q      <= '0;
            norm_q     <= '0;
            zero_q     <= 1'b0;
            tag_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s1_tag_q   <= s1_tag_d;
            s1_nz_q    <= s1_nz_d;
            s1_lz_q    <= s1_lz_d;
            s1_pc_q    <= s1_pc_d;
            o_valid_q  <= o_valid_d;
            cnt_q      <= cnt_d;
            norm_q     <= norm_d;
            zero_q     <= zero_d;
            tag_q      <= tag_d;
        end
    end

endmodule

// File: tb/tb_float_norm_pipe.sv
// Bench for float_norm_pipe: default 48/8 instance plus a 64/4 instance, checked
// against a bit-scan reference model with a scoreboard queue.
module tb_float_norm_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv48, or48, im48, ov48, ir48, oz48;
    logic [47:0] id48, on48;
    logic [6:0]  it48, ot48;
    logic [5:0]  oc48;

    logic        iv64, or64, im64, ov64, ir64, oz64;
    logic [63:0] id64, on64;
    logic [6:0]  it64, ot64;
    logic [6:0]  oc64;

    float_norm_pipe u_dut48 (
        .clk(clk), .rst(rst), .i_valid(iv48), .o_ready(or48), .i_mode(im48),
        .i_data(id48), .i_tag(it48), .o_valid(ov48), .i_ready(ir48),
        .o_cnt(oc48), .o_norm(on48), .o_zero(oz48), .o_tag(ot48)
    );

    float_norm_pipe #(.WIDTH(64), .GROUP(4), .TAG_W(7)) u_dut64 (
        .clk(clk), .rst(rst), .i_valid(iv64), .o_ready(or64), .i_mode(im64),
        .i_data(id64), .i_tag(it64), .o_valid(ov64), .i_ready(ir64),
        .o_cnt(oc64), .o_norm(on64), .o_zero(oz64), .o_tag(ot64)
    );

    typedef struct {
        logic [63:0] cnt;
        logic [63:0] norm;
        logic        zero;
        logic [6:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Reference: scan from the MSB for the first one; count ones directly.
    function automatic exp_t model(input logic [63:0] d, input bit m, input logic [6:0] t, input int w);
        exp_t e;
        int lz = 0;
        int pc = 0;
        bit found = 0;
        logic [63:0] mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        for (int i = w - 1; i >= 0; i--) begin
            if (!found) begin
                if (d[i]) found = 1;
                else lz++;
            end
            if (d[i]) pc++;
        end
        e.cnt  = m ? 64'(pc) : 64'(lz);
        e.norm = m ? (d & mask) : ((d << lz) & mask);
        e.zero = ((d & mask) == 64'd0);
        e.tag  = t;
        return e;
    endfunction

    task automatic drive(input bit sel, input bit v, input bit m, input logic [63:0] d,
                         input logic [6:0] t, input bit rdy);
        if (sel) begin
            iv64 = v; im64 = m; id64 = d; it64 = t; ir64 = rdy;
        end else begin
            iv48 = v; im48 = m; id48 = d[47:0]; it48 = t; ir48 = rdy;
        end
    endtask

    task automatic sample(input bit sel, output logic ov, output logic ordy,
                          output logic [63:0] cnt, output logic [63:0] norm,
                          output logic zero, output logic [6:0] tag);
        ov   = sel ? ov64 : ov48;
        ordy = sel ? or64 : or48;
        cnt  = sel ? 64'(oc64) : 64'(oc48);
        norm = sel ? on64 : 64'(on48);
        zero = sel ? oz64 : oz48;
        tag  = sel ? ot64 : ot48;
    endtask

    // One clock of stimulus with scoreboard checking; outputs sampled after negedge.
    task automatic cyc(input bit sel, input bit v, input bit m, input logic [63:0] d,
                       input logic [6:0] t, input bit rdy, output bit acc);
        logic ov, ordy, zero;
        logic [63:0] cnt, norm;
        logic [6:0] tag;
        exp_t e;
        @(negedge clk);
        drive(sel, v, m, d, t, rdy);
        #1;
        sample(sel, ov, ordy, cnt, norm, zero, tag);
        check("o_ready", 64'(ordy), 64'(!ov || rdy));
        if (ov) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(ov), 64'd0);
            end else begin
                e = sb[0];
                check("sb_cnt", cnt, e.cnt);
                check("sb_norm", norm, e.norm);
                check("sb_zero", 64'(zero), 64'(e.zero));
                check("sb_tag", 64'(tag), 64'(e.tag));
                if (rdy) begin
                    void'(sb.pop_front());
                    n_pop++;
                end
            end
        end
        acc = v && ordy;
        if (acc) sb.push_back(model(d, m, t, sel ? 64 : 48));
    endtask

    // Single operand into an idle pipe, literal expectations, exact 2-cycle latency.
    task automatic dir(input bit sel, input bit m, input logic [63:0] d, input logic [6:0] t,
                       input logic [63:0] ecnt, input logic [63:0] enorm, input bit ezero);
        logic ov, ordy, zero;
        logic [63:0] cnt, norm;
        logic [6:0] tag;
        @(negedge clk);
        drive(sel, 1, m, d, t, 1);
        #1;
        sample(sel, ov, ordy, cnt, norm, zero, tag);
        check("dir_ready", 64'(ordy), 64'd1);
        @(negedge clk);
        drive(sel, 0, 0, 64'd0, 7'd0, 1);
        #1;
        sample(sel, ov, ordy, cnt, norm, zero, tag);
        check("dir_lat1_valid", 64'(ov), 64'd0);
        @(negedge clk);
        #1;
        sample(sel, ov, ordy, cnt, norm, zero, tag);
        check("dir_valid", 64'(ov), 64'd1);
        check("dir_cnt", cnt, ecnt);
        check("dir_norm", norm, enorm);
        check("dir_zero", 64'(zero), 64'(ezero));
        check("dir_tag", 64'(tag), 64'(t));
    endtask

    task automatic drain(input bit sel);
        bit acc;
        for (int k = 0; k < 20 && sb.size() > 0; k++) cyc(sel, 0, 0, 64'd0, 7'd0, 1, acc);
        check("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        logic ov, ordy, zero;
        logic [63:0] cnt, norm, d;
        logic [6:0] tag;
        logic [63:0] ops_d [5];
        bit ops_m [5];
        bit acc, rdy, v, m;
        int idx;

        rst = 1'b1;
        drive(0, 0, 0, 64'd0, 7'd0, 1);
        drive(1, 0, 0, 64'd0, 7'd0, 1);

        // Reset state of both instances
        @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sample(s[0], ov, ordy, cnt, norm, zero, tag);
            check("rst_valid", 64'(ov), 64'd0);
            check("rst_cnt", cnt, 64'd0);
            check("rst_norm", norm, 64'd0);
            check("rst_zero", 64'(zero), 64'd0);
            check("rst_tag", 64'(tag), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        sample(0, ov, ordy, cnt, norm, zero, tag);
        check("post_rst_ready", 64'(ordy), 64'd1);

        // Directed mode 0 / mode 1 cases at 48 bits
        dir(0, 0, 64'h0000_0100_0000, 7'h15, 64'd23, 64'h8000_0000_0000, 0);
        dir(0, 0, 64'h8000_0000_0001, 7'h01, 64'd0,  64'h8000_0000_0001, 0);
        dir(0, 0, 64'h0000_0000_0001, 7'h02, 64'd47, 64'h8000_0000_0000, 0);
        dir(0, 0, 64'h0,              7'h03, 64'd48, 64'h0,              1);
        dir(0, 1, 64'hFFFF_FFFF_FFFF, 7'h04, 64'd48, 64'hFFFF_FFFF_FFFF, 0);
        dir(0, 1, 64'h0F0F_0000_0001, 7'h05, 64'd9,  64'h0F0F_0000_0001, 0);
        dir(0, 1, 64'h0,              7'h06, 64'd0,  64'h0,              1);

        // Five back-to-back operands, 3-cycle output stall once o_valid rises
        ops_d[0] = 64'h0000_0000_0F00; ops_m[0] = 0;
        ops_d[1] = 64'h1234_5678_9ABC; ops_m[1] = 1;
        ops_d[2] = 64'h0000_8000_0000; ops_m[2] = 0;
        ops_d[3] = 64'h0000_0000_0003; ops_m[3] = 1;
        ops_d[4] = 64'h0001_0000_0000; ops_m[4] = 0;
        idx = 0;
        n_pop = 0;
        for (int k = 0; k < 12; k++) begin
            rdy = !(k >= 2 && k < 5);
            if (idx < 5) cyc(0, 1, ops_m[idx], ops_d[idx], 7'(idx + 8), rdy, acc);
            else         cyc(0, 0, 0, 64'd0, 7'd0, rdy, acc);
            if (acc) idx++;
        end
        check("stream_accepted", 64'(idx), 64'd5);
        check("stream_results", 64'(n_pop), 64'd5);
        drain(0);

        // Random traffic with random backpressure at 48 bits
        for (int k = 0; k < 300; k++) begin
            v = ($urandom_range(0, 3) != 0);
            m = $urandom_range(0, 1) == 1;
            d = ({$urandom, $urandom} >> $urandom_range(0, 63)) & 64'h0000_FFFF_FFFF_FFFF;
            rdy = ($urandom_range(0, 3) != 0);
            cyc(0, v, m, d, 7'($urandom), rdy, acc);
        end
        drain(0);

        // Reset with two operands in flight
        cyc(0, 1, 0, 64'h0000_0000_1000, 7'h33, 1, acc);
        cyc(0, 1, 1, 64'h0000_FFFF_0000, 7'h34, 1, acc);
        @(negedge clk);
        drive(0, 0, 0, 64'd0, 7'd0, 1);
        #1;
        rst = 1'b1;
        #1;
        sample(0, ov, ordy, cnt, norm, zero, tag);
        check("midrst_valid", 64'(ov), 64'd0);
        check("midrst_cnt", cnt, 64'd0);
        check("midrst_norm", norm, 64'd0);
        check("midrst_zero", 64'(zero), 64'd0);
        check("midrst_tag", 64'(tag), 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 64'd0, 7'd0, 1, acc);
            sample(0, ov, ordy, cnt, norm, zero, tag);
            check("no_stale_valid", 64'(ov), 64'd0);
        end
        dir(0, 0, 64'h0000_0000_8000, 7'h40, 64'd32, 64'h8000_0000_0000, 0);

        // 64-bit / group-4 instance
        dir(1, 0, 64'h0, 7'h11, 64'd64, 64'h0, 1);
        dir(1, 1, 64'h0, 7'h12, 64'd0,  64'h0, 1);
        for (int b = 0; b < 64; b++) begin
            cyc(1, 1, 0, 64'd1 << b, 7'(b), 1, acc);
            cyc(1, 1, 1, 64'd1 << b, 7'(b), 1, acc);
        end
        drain(1);
        for (int k = 0; k < 200; k++) begin
            v = ($urandom_range(0, 3) != 0);
            m = $urandom_range(0, 1) == 1;
            d = {$urandom, $urandom} >> $urandom_range(0, 63);
            rdy = ($urandom_range(0, 3) != 0);
            cyc(1, v, m, d, 7'($urandom), rdy, acc);
        end
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
